// File: rtl/keypad_pkg.sv
// keypad_pkg
// Shared definitions for the 3x4 keypad scanner: matrix dimensions, key-code
// constants, the scan-state enum and the (row, column) -> key-code mapping.
package keypad_pkg;

    localparam int NUM_ROWS = 4;
    localparam int NUM_COLS = 3;
    localparam int NUM_KEYS = NUM_ROWS * NUM_COLS;

    localparam logic [3:0] KEY_0     = 4'd0;
    localparam logic [3:0] KEY_1     = 4'd1;
    localparam logic [3:0] KEY_2     = 4'd2;
    localparam logic [3:0] KEY_3     = 4'd3;
    localparam logic [3:0] KEY_4     = 4'd4;
    localparam logic [3:0] KEY_5     = 4'd5;
    localparam logic [3:0] KEY_6     = 4'd6;
    localparam logic [3:0] KEY_7     = 4'd7;
    localparam logic [3:0] KEY_8     = 4'd8;
    localparam logic [3:0] KEY_9     = 4'd9;
    localparam logic [3:0] KEY_STAR  = 4'd10;
    localparam logic [3:0] KEY_SHARP = 4'd11;

    typedef enum logic [1:0] {
        COL0 = 2'd0,
        COL1 = 2'd1,
        COL2 = 2'd2
    } scan_state_e;

    // Telephone layout: rows top to bottom, columns left to right.
    function automatic logic [3:0] key_code_of(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        case ({row, col})
            4'b00_00: code = KEY_1;
            4'b00_01: code = KEY_2;
            4'b00_10: code = KEY_3;
            4'b01_00: code = KEY_4;
            4'b01_01: code = KEY_5;
            4'b01_10: code = KEY_6;
            4'b10_00: code = KEY_7;
            4'b10_01: code = KEY_8;
            4'b10_10: code = KEY_9;
            4'b11_00: code = KEY_STAR;
            4'b11_10: code = KEY_SHARP;
            default:  code = KEY_0;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// key_debounce
// Per-key debouncer. A key's raw level is looked at only when sample_i is
// high; DEBOUNCE_CNT consecutive disagreeing samples flip the debounced level.
// Ports:
//   clk_i     system clock
//   rst_ni    asynchronous active-low reset
//   sample_i  sample strobe for this key
//   raw_i     raw key level (1 = pressed), valid when sample_i is high
//   level_o   debounced key level (registered)
//   rise_o    high in the cycle whose edge confirms a 0->1 transition
module key_debounce #(
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sample_i,
    input  logic raw_i,
    output logic level_o,
    output logic rise_o
);
    import keypad_pkg::*;

    // The counter never has to hold DEBOUNCE_CNT itself: it clears on confirm.
    localparam int CW = (DEBOUNCE_CNT < 2) ? 1 : $clog2(DEBOUNCE_CNT);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CNT - 1);

    logic          level_q, level_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          confirm;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            level_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    assign confirm = sample_i && (raw_i != level_q) && (cnt_q == CNT_LAST);

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        if (sample_i) begin
            if (raw_i == level_q) begin
                cnt_d = '0;
            end else if (confirm) begin
                level_d = ~level_q;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    // Combinational so the event register loads on the same edge as level_q.
    assign rise_o  = confirm && raw_i;
    assign level_o = level_q;

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner
// Scans a 3x4 telephone keypad, debounces every key and emits one-shot press
// events through a one-entry valid/ready holding register.
// Ports:
//   CLK, RST              clock, asynchronous active-low reset
//   row_in[3:0]           matrix rows, active-low
//   col_out[2:0]          column strobes, active-low one-hot
//   BTN1..BTN9, BTN_0,
//   BTN_star, BTN_sharp   debounced key levels, active-high
//   key_valid/key_code    pending press event and its code
//   key_ready             consumer accepts the pending event
//   overflow              sticky: a press event was dropped
module keypad_scanner #(
    parameter int SCAN_DIV     = 4,
    parameter int DEBOUNCE_CNT = 3
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [3:0] row_in,
    output logic [2:0] col_out,
    output logic       BTN1,
    output logic       BTN2,
    output logic       BTN3,
    output logic       BTN4,
    output logic       BTN5,
    output logic       BTN6,
    output logic       BTN7,
    output logic       BTN8,
    output logic       BTN9,
    output logic       BTN_0,
    output logic       BTN_star,
    output logic       BTN_sharp,
    output logic       key_valid,
    output logic [3:0] key_code,
    input  logic       key_ready,
    output logic       overflow
);
    import keypad_pkg::*;

    localparam int DIV_W = (SCAN_DIV < 2) ? 1 : $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);

    scan_state_e          state_q, state_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic                 strobe;
    logic [NUM_COLS-1:0]  sample_col;
    logic [NUM_KEYS-1:0]  level, rise;

    logic                 evt_any, evt_multi;
    logic [3:0]           evt_code;
    logic                 valid_q, valid_d;
    logic [3:0]           code_q, code_d;
    logic                 ovf_q, ovf_d;

    // Scan FSM: state register and divide counter.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= COL0;
            div_q   <= '0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
        end
    end

    // Rows are sampled on the last cycle of each column period.
    assign strobe = (div_q == DIV_LAST);
    assign div_d  = strobe ? '0 : div_q + 1'b1;

    // Scan FSM: next state.
    always_comb begin
        state_d = state_q;
        if (strobe) begin
            case (state_q)
                COL0:    state_d = COL1;
                COL1:    state_d = COL2;
                default: state_d = COL0;
            endcase
        end
    end

    // Scan FSM: outputs (column strobe and per-column sample enable).
    always_comb begin
        col_out    = 3'b111;
        sample_col = '0;
        case (state_q)
            COL0: begin
                col_out       = 3'b110;
                sample_col[0] = strobe;
            end
            COL1: begin
                col_out       = 3'b101;
                sample_col[1] = strobe;
            end
            COL2: begin
                col_out       = 3'b011;
                sample_col[2] = strobe;
            end
            default: begin
                col_out    = 3'b111;
                sample_col = '0;
            end
        endcase
    end

    // Sample demux: key (r, c) lives at index r*NUM_COLS + c.
    for (genvar r = 0; r < NUM_ROWS; r++) begin : g_row
        for (genvar c = 0; c < NUM_COLS; c++) begin : g_col
            key_debounce #(
                .DEBOUNCE_CNT(DEBOUNCE_CNT)
            ) u_deb (
                .clk_i   (CLK),
                .rst_ni  (RST),
                .sample_i(sample_col[c]),
                .raw_i   (~row_in[r]),
                .level_o (level[r*NUM_COLS + c]),
                .rise_o  (rise[r*NUM_COLS + c])
            );
        end
    end

    // Priority encoder: rows scanned from 0 upward so the lowest row wins;
    // any further rise in the same cycle is a dropped event.
    always_comb begin
        evt_any   = 1'b0;
        evt_multi = 1'b0;
        evt_code  = KEY_0;
        for (int r = 0; r < NUM_ROWS; r++) begin
            for (int c = 0; c < NUM_COLS; c++) begin
                if (rise[r*NUM_COLS + c]) begin
                    if (evt_any) begin
                        evt_multi = 1'b1;
                    end else begin
                        evt_any  = 1'b1;
                        evt_code = key_code_of(2'(r), 2'(c));
                    end
                end
            end
        end
    end

    // Event holding register and sticky overflow.
    always_comb begin
        valid_d = valid_q;
        code_d  = code_q;
        ovf_d   = ovf_q | evt_multi;
        if (!valid_q || key_ready) begin
            valid_d = evt_any;
            if (evt_any) begin
                code_d = evt_code;
            end
        end else if (evt_any) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            valid_q <= 1'b0;
            code_q  <= KEY_0;
            ovf_q   <= 1'b0;
        end else begin
            valid_q <= valid_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign key_valid = valid_q;
    assign key_code  = code_q;
    assign overflow  = ovf_q;

    assign BTN1      = level[0];
    assign BTN2      = level[1];
    assign BTN3      = level[2];
    assign BTN4      = level[3];
    assign BTN5      = level[4];
    assign BTN6      = level[5];
    assign BTN7      = level[6];
    assign BTN8      = level[7];
    assign BTN9      = level[8];
    assign BTN_star  = level[9];
    assign BTN_0     = level[10];
    assign BTN_sharp = level[11];

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner
// Directed bench for keypad_scanner with SCAN_DIV = 4, DEBOUNCE_CNT = 3.
// A behavioural key matrix pulls a row low while the column of a held key is
// strobed. After each reset release, posedge k lands at the end of scan cycle
// k-1, so column c of frame f is sampled at edge 12*f + 4*c + 4.
module tb_keypad_scanner;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic [3:0] row_in;
    logic [2:0] col_out;
    logic       BTN1, BTN2, BTN3, BTN4, BTN5, BTN6, BTN7, BTN8, BTN9;
    logic       BTN_0, BTN_star, BTN_sharp;
    logic       key_valid;
    logic [3:0] key_code;
    logic       key_ready = 1'b0;
    logic       overflow;

    logic [11:0] held = '0;   // index r*3 + c
    int          cyc = 0;
    int          total = 0;
    int          bad = 0;
    int          evt_cnt = 0;
    logic        vld_prev = 1'b0;

    keypad_scanner #(
        .SCAN_DIV    (4),
        .DEBOUNCE_CNT(3)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .row_in   (row_in),
        .col_out  (col_out),
        .BTN1     (BTN1),
        .BTN2     (BTN2),
        .BTN3     (BTN3),
        .BTN4     (BTN4),
        .BTN5     (BTN5),
        .BTN6     (BTN6),
        .BTN7     (BTN7),
        .BTN8     (BTN8),
        .BTN9     (BTN9),
        .BTN_0    (BTN_0),
        .BTN_star (BTN_star),
        .BTN_sharp(BTN_sharp),
        .key_valid(key_valid),
        .key_code (key_code),
        .key_ready(key_ready),
        .overflow (overflow)
    );

    always #5 CLK = ~CLK;

    always_comb begin
        row_in = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 3; c++)
                if (held[r*3 + c] && !col_out[c]) row_in[r] = 1'b0;
    end

    // Counts key_valid rising edges (each one is a fresh event).
    always @(negedge CLK) begin
        if (key_valid && !vld_prev) evt_cnt <= evt_cnt + 1;
        vld_prev <= key_valid;
    end

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b1;
        cyc = 0;
    endtask

    // Advance to scan cycle k and settle 2 ns after its opening edge.
    task automatic go_to(input int k);
        while (cyc < k) begin
            @(posedge CLK);
            cyc++;
        end
        #2;
    endtask

    task automatic test_reset();
        held = '0;
        held[4] = 1'b1;            // key 5
        key_ready = 1'b0;
        do_reset();
        go_to(35);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'd5) begin
            bad++;
            $display("FAIL reset_pre valid/code got=%b/%0d want=1/5", key_valid, key_code);
        end
        #1 RST = 1'b0;
        #1;
        total++;
        if (col_out !== 3'b110) begin
            bad++;
            $display("FAIL reset_col got=%b want=110", col_out);
        end
        total++;
        if ({BTN1, BTN2, BTN3, BTN4, BTN5, BTN6, BTN7, BTN8, BTN9, BTN_0, BTN_star, BTN_sharp} !== 12'h000) begin
            bad++;
            $display("FAIL reset_btn got=%b%b%b%b%b%b%b%b%b%b%b%b want=0", BTN1, BTN2, BTN3, BTN4,
                     BTN5, BTN6, BTN7, BTN8, BTN9, BTN_0, BTN_star, BTN_sharp);
        end
        total++;
        if (key_valid !== 1'b0 || key_code !== 4'd0 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL reset_evt valid/code/ovf got=%b/%0d/%b want=0/0/0", key_valid, key_code, overflow);
        end
        held = '0;
        @(negedge CLK);
        RST = 1'b1;
        cyc = 0;
        begin
            int          pts[7];
            logic [2:0]  exp_col[7];
            pts = '{0, 3, 4, 7, 8, 11, 12};
            exp_col = '{3'b110, 3'b110, 3'b101, 3'b101, 3'b011, 3'b011, 3'b110};
            for (int i = 0; i < 7; i++) begin
                go_to(pts[i]);
                total++;
                if (col_out !== exp_col[i]) begin
                    bad++;
                    $display("FAIL scan_col cyc=%0d got=%b want=%b", pts[i], col_out, exp_col[i]);
                end
            end
        end
    endtask

    task automatic test_press5();
        int e0;
        held = '0;
        key_ready = 1'b1;
        do_reset();
        e0 = evt_cnt;
        held[4] = 1'b1;            // row1, col1; samples at edges 8, 20, 32
        go_to(31);
        total++;
        if (BTN5 !== 1'b0 || key_valid !== 1'b0) begin
            bad++;
            $display("FAIL press5_early btn/valid got=%b/%b want=0/0", BTN5, key_valid);
        end
        go_to(32);
        total++;
        if (BTN5 !== 1'b1 || key_valid !== 1'b1 || key_code !== 4'd5) begin
            bad++;
            $display("FAIL press5_rise btn/valid/code got=%b/%b/%0d want=1/1/5", BTN5, key_valid, key_code);
        end
        go_to(33);
        total++;
        if (key_valid !== 1'b0 || key_code !== 4'd5) begin
            bad++;
            $display("FAIL press5_xfer valid/code got=%b/%0d want=0/5", key_valid, key_code);
        end
        go_to(40);
        held[4] = 1'b0;            // release samples at 44, 56, 68
        go_to(67);
        total++;
        if (BTN5 !== 1'b1) begin
            bad++;
            $display("FAIL press5_hold got=%b want=1", BTN5);
        end
        go_to(68);
        total++;
        if (BTN5 !== 1'b0) begin
            bad++;
            $display("FAIL press5_fall got=%b want=0", BTN5);
        end
        go_to(75);
        total++;
        if (evt_cnt - e0 !== 1 || overflow !== 1'b0) begin
            bad++;
            $display("FAIL press5_events count/ovf got=%0d/%b want=1/0", evt_cnt - e0, overflow);
        end
    endtask

    task automatic test_bounce();
        int e0;
        held = '0;
        key_ready = 1'b1;
        do_reset();
        e0 = evt_cnt;
        held[2] = 1'b1;            // key 3: row0, col2; samples at 12, 24, 36
        go_to(30);
        held[2] = 1'b0;
        go_to(40);
        held[2] = 1'b1;            // another two-sample bounce: 48, 60
        go_to(62);
        held[2] = 1'b0;
        go_to(80);
        total++;
        if (BTN3 !== 1'b0 || evt_cnt - e0 !== 0) begin
            bad++;
            $display("FAIL bounce btn3/events got=%b/%0d want=0/0", BTN3, evt_cnt - e0);
        end
    endtask

    task automatic test_backpressure();
        held = '0;
        key_ready = 1'b0;
        do_reset();
        held[0] = 1'b1;            // key 1: samples 4, 16, 28
        held[8] = 1'b1;            // key 9: samples 12, 24, 36
        go_to(28);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'd1 || BTN1 !== 1'b1) begin
            bad++;
            $display("FAIL bp_first valid/code/btn1 got=%b/%0d/%b want=1/1/1", key_valid, key_code, BTN1);
        end
        go_to(35);
        total++;
        if (overflow !== 1'b0 || BTN9 !== 1'b0) begin
            bad++;
            $display("FAIL bp_before ovf/btn9 got=%b/%b want=0/0", overflow, BTN9);
        end
        go_to(37);
        total++;
        if (BTN9 !== 1'b1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL bp_drop btn9/ovf got=%b/%b want=1/1", BTN9, overflow);
        end
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'd1) begin
            bad++;
            $display("FAIL bp_held valid/code got=%b/%0d want=1/1", key_valid, key_code);
        end
        key_ready = 1'b1;
        go_to(38);
        total++;
        if (key_valid !== 1'b0 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL bp_release valid/ovf got=%b/%b want=0/1", key_valid, overflow);
        end
    endtask

    task automatic test_simultaneous();
        int e0;
        held = '0;
        key_ready = 1'b1;
        do_reset();
        e0 = evt_cnt;
        held[6] = 1'b1;            // key 7: row2, col0
        held[9] = 1'b1;            // star:  row3, col0; both sampled 4, 16, 28
        go_to(27);
        total++;
        if (overflow !== 1'b0 || key_valid !== 1'b0) begin
            bad++;
            $display("FAIL simul_early ovf/valid got=%b/%b want=0/0", overflow, key_valid);
        end
        go_to(28);
        total++;
        if (key_valid !== 1'b1 || key_code !== 4'd7) begin
            bad++;
            $display("FAIL simul_code valid/code got=%b/%0d want=1/7", key_valid, key_code);
        end
        total++;
        if (BTN7 !== 1'b1 || BTN_star !== 1'b1 || overflow !== 1'b1) begin
            bad++;
            $display("FAIL simul_btn btn7/star/ovf got=%b/%b/%b want=1/1/1", BTN7, BTN_star, overflow);
        end
        go_to(45);
        total++;
        if (evt_cnt - e0 !== 1) begin
            bad++;
            $display("FAIL simul_events got=%0d want=1", evt_cnt - e0);
        end
    endtask

    task automatic test_midreset();
        int e0;
        held = '0;
        key_ready = 1'b1;
        do_reset();
        e0 = evt_cnt;
        held[7] = 1'b1;            // key 8: row2, col1; samples 8, 20 before reset
        go_to(22);
        total++;
        if (BTN8 !== 1'b0) begin
            bad++;
            $display("FAIL midrst_pre got=%b want=0", BTN8);
        end
        do_reset();                // key stays held
        go_to(31);
        total++;
        if (BTN8 !== 1'b0 || key_valid !== 1'b0) begin
            bad++;
            $display("FAIL midrst_early btn8/valid got=%b/%b want=0/0", BTN8, key_valid);
        end
        go_to(32);
        total++;
        if (BTN8 !== 1'b1 || key_valid !== 1'b1 || key_code !== 4'd8) begin
            bad++;
            $display("FAIL midrst_evt btn8/valid/code got=%b/%b/%0d want=1/1/8", BTN8, key_valid, key_code);
        end
        total++;
        if (evt_cnt - e0 !== 0) begin
            // Monitor counts at the next negedge, so the fresh event is not yet counted.
            bad++;
            $display("FAIL midrst_count got=%0d want=0", evt_cnt - e0);
        end
    endtask

    initial begin
        test_reset();
        test_press5();
        test_bounce();
        test_backpressure();
        test_simultaneous();
        test_midreset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans the 3x4 telephone-style key matrix of the LaunchPad board and produces the twelve debounced button level signals (BTN1..BTN9, BTN_0, BTN_star, BTN_sharp) that the LaunchPad core consumes. It also emits one-shot key-press events with a valid/ready handshake for the pattern recorder.

## Interface
Parameters:
- SCAN_DIV, 4: clock cycles each column strobe is held; must be ≥ 2.
- DEBOUNCE_CNT, 3: consecutive agreeing samples needed to change a key's debounced state; must be ≥ 1.

Ports:
- CLK  in  1  single system clock, rising edge.
- RST  in  1  reset, asynchronous and active-low.
- row_in  in  4  matrix rows, active-low. Row 0 = {1,2,3}, row 1 = {4,5,6}, row 2 = {7,8,9}, row 3 = {*,0,#}.
- col_out  out  3  column strobes, active-low one-hot. Col 0 is the left column.
- BTN1..BTN9, BTN_0, BTN_star, BTN_sharp  out  1 each  debounced key levels, active-high.
- key_valid  out  1  press event pending.
- key_code  out  4  event code: digits 0–9, star = 10, sharp = 11.
- key_ready  in  1  consumer accepts the event.
- overflow  out  1  sticky flag: at least one press event was dropped.

## Operation
- Scan FSM has states COL0 → COL1 → COL2 → COL0. The FSM spends SCAN_DIV cycles in each state, driven by a divide counter that runs 0..SCAN_DIV-1.
- col_out drives low only the active column.
- row_in is sampled on the last cycle of each column period, after SCAN_DIV-1 settle cycles. The sample goes to the raw bits of the active column's four keys.
- Each key is sampled once per frame. One frame = 3*SCAN_DIV cycles.
- Debounce, per key:
  - A sample that differs from the debounced state increments that key's counter.
  - A sample that equals the debounced state clears the counter.
  - When the counter reaches DEBOUNCE_CNT, the debounced state toggles and the counter clears.
- BTN outputs are the debounced states, registered.
- Press event: generated on a debounced 0→1 transition only. Releases generate no event.
- Simultaneous presses: several keys in one column may confirm on the same sample. The lowest row index wins. Each loser is dropped and sets overflow.
- One-entry event holding register:
  - Empty: a new event loads it, and key_valid rises.
  - key_valid && key_ready: the event is transferred. If a new event arrives in the same cycle it is loaded, and valid stays high. Otherwise valid falls.
  - key_valid && !key_ready and a new event arrives: the new event is dropped and overflow is set. The held event is unchanged.
- overflow is cleared only by reset.
- key_code is held stable while key_valid is high. It keeps its last value after a transfer.

## Timing
- Reset values: col_out = 3'b110, all BTN = 0, key_valid = 0, key_code = 0, overflow = 0. FSM in COL0, all counters and raw/debounced state 0.
- Reset takes effect asynchronously. Asserting it mid-scan or mid-debounce discards all partial counts and any pending event.
- Latency: the BTN rise and key_valid rise occur in the cycle after the sampling edge that confirms the press. Both change on the same edge.
- Press latency from a stable row level: DEBOUNCE_CNT frames, plus up to one frame of phase.
- A key held through reset release is re-detected from state 0. It produces a fresh event after DEBOUNCE_CNT frames.
- The handshake transfers on any rising edge where key_valid && key_ready are both high.

## Structure
- Package keypad_pkg holds:
  - NUM_ROWS = 4 and NUM_COLS = 3.
  - The key-code constants (KEY_0..KEY_9, KEY_STAR = 10, KEY_SHARP = 11).
  - The row/column → code mapping function.
  - The scan-state enum (COL0, COL1, COL2).
- Sub-module key_debounce (one raw sample strobe in, one debounced level plus rise pulse out) is instantiated 12 times.
- The top level contains:
  - the scan FSM and divide counter,
  - sample demux,
  - priority encoder,
  - event register,
  - the overflow flag.

## Test plan
All tests use SCAN_DIV = 4 and DEBOUNCE_CNT = 3, so one frame = 12 cycles.
1. Reset: hold RST low mid-run → outputs take their reset values immediately; after release col_out cycles 110→101→011 every 4 cycles.
2. Press 5 (row1 low while col1 strobed), key_ready = 1 → BTN5 rises on the 3rd col1 sample; key_valid high one cycle with key_code = 5; no event on release, and BTN5 falls 3 samples after release.
3. Bounce: row0 low during col2 for 2 samples, then high → BTN3 never rises, no event.
4. Backpressure, key_ready = 0: press 1, then 9 → key_valid held with code 1; code 9 dropped and overflow = 1; BTN9 still rises. Raising key_ready drops key_valid the next cycle.
5. Simultaneous: rows 2 and 3 low during col0, same frames → one event with code 7; BTN7 and BTN_star both rise; overflow = 1.
6. Mid-debounce reset: press 8 for 2 samples, pulse RST, keep pressed → event code 8 arrives only after 3 full frames post-reset.
